// File: rtl/board_pkg.sv
// Shared definitions for the memory-matrix board generator and its neighbours
// (game FSM, guess-check datapath): board width, FSM states, LFSR constants
// and the difficulty clamp rule.
package board_pkg;

  localparam int          BOARD_W      = 8;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Requested tile count -> lit-tile target: zero becomes one, and anything
  // above the board width saturates at the width.
  function automatic logic [4:0] clamp_target(input logic [3:0] n, input int w);
    logic [4:0] wt;
    wt = 5'(w);
    if (n == 4'd0) return 5'd1;
    else if ({1'b0, n} > wt) return wt;
    else return {1'b0, n};
  endfunction

endpackage

// File: rtl/board_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR (right shift). Runs in every state so the
// player's start timing decides which part of the sequence seeds a board.
module lfsr16
  import board_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // Load the seed on reset, otherwise shift and fold in the taps.
  always_ff @(posedge clk) begin
    if (reset) q <= seed;
    else       q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
  end

endmodule

// File: rtl/board_gen.sv
// Hidden solution board generator for the memory-matrix game.
// Optional build macro BOARD_GEN_NO_REPEAT_EN: refuse to deliver a board that
// equals the previously delivered one (unless every tile is lit or the board
// was forced by the fill watchdog).
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no board since reset; waiting for start
//   FILL  | placing random tiles until the latched target count is lit
//   DONE  | board held and valid; a start begins a new fill
module board_gen
  import board_pkg::*;
#(
  parameter int          WIDTH      = BOARD_W,
  parameter logic [15:0] SEED       = DEFAULT_SEED,
  parameter int          MAX_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       num_tiles,
  output logic             busy,
  output logic             board_done,
  output logic             board_valid,
  output logic [WIDTH-1:0] board
);

  localparam int                 IDX_W     = $clog2(WIDTH);
  localparam int                 TMR_W     = $clog2(MAX_CYCLES + 1);
  localparam logic [4:0]         WIDTH_T   = 5'(WIDTH);
  localparam logic [TMR_W-1:0]   TMR_LIMIT = TMR_W'(MAX_CYCLES);

  logic [15:0]      lfsr_q;
  logic             unused_lfsr_hi;
  logic [IDX_W-1:0] idx;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] accum_q, accum_n;
  logic [WIDTH-1:0] board_q, board_n;
  logic [4:0]       count_q, count_n;
  logic [4:0]       target_q, target_n;
  logic [TMR_W-1:0] timer_q, timer_n;
  logic             valid_q, valid_n;
  logic             done_q, done_n;
  logic [WIDTH-1:0] fill_acc;
  logic [4:0]       fill_cnt;
  logic             repeat_hit;
`ifdef BOARD_GEN_NO_REPEAT_EN
  logic [WIDTH-1:0] prev_q, prev_n;
  logic             forced_q, forced_n;
`endif

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  assign idx            = lfsr_q[IDX_W-1:0];
  assign unused_lfsr_hi = ^lfsr_q[15:IDX_W];

  // Watchdog completion: light the lowest clear tiles until the target is met.
  always_comb begin
    fill_acc = accum_q;
    fill_cnt = count_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (!fill_acc[i] && (fill_cnt < target_q)) begin
        fill_acc[i] = 1'b1;
        fill_cnt    = fill_cnt + 5'd1;
      end
    end
  end

  // A finished board that merely repeats the last one gets refilled; prev
  // clears to zero on reset and a real board is never empty, so the first
  // board always passes.
  always_comb begin
    repeat_hit = 1'b0;
`ifdef BOARD_GEN_NO_REPEAT_EN
    repeat_hit = !forced_q && (target_q < WIDTH_T) && (accum_q == prev_q);
`endif
  end

  // Next-state and datapath updates for the fill sequencer.
  always_comb begin
    state_n  = state_q;
    accum_n  = accum_q;
    board_n  = board_q;
    count_n  = count_q;
    target_n = target_q;
    timer_n  = timer_q;
    valid_n  = valid_q;
    done_n   = 1'b0;
`ifdef BOARD_GEN_NO_REPEAT_EN
    prev_n   = prev_q;
    forced_n = forced_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          target_n = clamp_target(num_tiles, WIDTH);
          accum_n  = '0;
          count_n  = 5'd0;
          timer_n  = '0;
          valid_n  = 1'b0;
          state_n  = FILL;
`ifdef BOARD_GEN_NO_REPEAT_EN
          forced_n = 1'b0;
`endif
        end
      end
      FILL: begin
        if (count_q == target_q) begin
          if (repeat_hit) begin
            accum_n = '0;
            count_n = 5'd0;
            timer_n = '0;
          end else begin
            board_n = accum_q;
            valid_n = 1'b1;
            done_n  = 1'b1;
            state_n = DONE;
`ifdef BOARD_GEN_NO_REPEAT_EN
            prev_n  = accum_q;
`endif
          end
        end else if (timer_q == TMR_LIMIT) begin
          accum_n = fill_acc;
          count_n = fill_cnt;
`ifdef BOARD_GEN_NO_REPEAT_EN
          forced_n = 1'b1;
`endif
        end else begin
          if (!accum_q[idx]) begin
            accum_n[idx] = 1'b1;
            count_n      = count_q + 5'd1;
          end
          timer_n = timer_q + TMR_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      accum_q  <= '0;
      board_q  <= '0;
      count_q  <= 5'd0;
      target_q <= 5'd0;
      timer_q  <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef BOARD_GEN_NO_REPEAT_EN
      prev_q   <= '0;
      forced_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_n;
      accum_q  <= accum_n;
      board_q  <= board_n;
      count_q  <= count_n;
      target_q <= target_n;
      timer_q  <= timer_n;
      valid_q  <= valid_n;
      done_q   <= done_n;
`ifdef BOARD_GEN_NO_REPEAT_EN
      prev_q   <= prev_n;
      forced_q <= forced_n;
`endif
    end
  end

  assign busy        = (state_q == FILL);
  assign board_done  = done_q;
  assign board_valid = valid_q;
  assign board       = board_q;

endmodule

// File: tb/tb_board_gen.sv
// Bench for board_gen: a default instance plus one with a tiny watchdog limit,
// both driven together and compared against a sequence-level reference model.
module tb_board_gen;
  import board_pkg::*;

  localparam int WD_MAX = 6;
`ifdef BOARD_GEN_NO_REPEAT_EN
  localparam bit NO_REPEAT = 1'b1;
`else
  localparam bit NO_REPEAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] num_tiles;
  logic       busy_m, done_m, valid_m;
  logic [7:0] board_m;
  logic       busy_w, done_w, valid_w;
  logic [7:0] board_w;

  board_gen dut (
    .clk(clk), .reset(reset), .start(start), .num_tiles(num_tiles),
    .busy(busy_m), .board_done(done_m), .board_valid(valid_m), .board(board_m)
  );

  board_gen #(.MAX_CYCLES(WD_MAX)) dut_wd (
    .clk(clk), .reset(reset), .start(start), .num_tiles(num_tiles),
    .busy(busy_w), .board_done(done_w), .board_valid(valid_w), .board(board_w)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] m_lfsr   = 16'hACE1;
  logic [7:0]  prev_m, prev_w;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSR: the value the design holds during the current cycle.
  always @(posedge clk) m_lfsr <= reset ? 16'hACE1 : lfsr_step(m_lfsr);

  // Board and completion edge (counted from the edge that accepts start),
  // derived from the LFSR sequence alone.
  function automatic void predict(input logic [15:0] l0, input int tgt, input int maxc,
                                  input logic [7:0] prev, output logic [7:0] brd,
                                  output int edges);
    logic [15:0] v;
    logic [7:0]  a;
    int          c, e;
    bit          forced;
    v = l0; e = 0; brd = 8'h00; edges = 0;
    for (int att = 0; att < 64; att++) begin
      a = 8'h00; c = 0; forced = 1'b0;
      for (int j = 0; j < maxc && c < tgt; j++) begin
        v = lfsr_step(v); e++;
        if (!a[v[2:0]]) begin a[v[2:0]] = 1'b1; c++; end
      end
      if (c < tgt) begin
        v = lfsr_step(v); e++; forced = 1'b1;
        for (int i = 0; i < 8; i++) if (!a[i] && c < tgt) begin a[i] = 1'b1; c++; end
      end
      v = lfsr_step(v); e++;
      brd = a; edges = e;
      if (!NO_REPEAT || forced || tgt == 8 || a != prev) return;
    end
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_board(input logic [3:0] n, input int mid_k, input logic [3:0] mid_n);
    int tgt, e_m, e_w, got_m, got_w, nd_m, nd_w, limit;
    logic [7:0] exp_m, exp_w, old_m;
    tgt = (n == 4'd0) ? 1 : ((n > 4'd8) ? 8 : int'(n));
    old_m = prev_m;
    predict(m_lfsr, tgt, 255, prev_m, exp_m, e_m);
    predict(m_lfsr, tgt, WD_MAX, prev_w, exp_w, e_w);
    num_tiles = n; start = 1'b1;
    tick();
    start = 1'b0;
    check_val("busy_after_start", busy_m, 1);
    check_val("wd_busy_after_start", busy_w, 1);
    check_val("valid_drop_on_start", valid_m, 0);
    check_val("board_held_on_start", board_m, prev_m);
    got_m = -1; got_w = -1; nd_m = 0; nd_w = 0;
    limit = ((e_m > e_w) ? e_m : e_w) + 2;
    if (limit > 3000) limit = 3000;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (done_m) begin nd_m++; if (got_m < 0) got_m = k; end
      if (done_w) begin nd_w++; if (got_w < 0) got_w = k; end
      if (k == mid_k) begin start = 1'b1; num_tiles = mid_n; end
      else start = 1'b0;
    end
    start = 1'b0;
    check_val("done_count", nd_m, 1);
    check_val("done_latency", got_m, e_m);
    check_val("board_model", board_m, exp_m);
    check_val("board_popcount", $countones(board_m), tgt);
    check_val("valid_after_done", valid_m, 1);
    check_val("busy_after_done", busy_m, 0);
    check_val("wd_done_count", nd_w, 1);
    check_val("wd_done_latency", got_w, e_w);
    check_val("wd_board_model", board_w, exp_w);
    check_val("wd_board_popcount", $countones(board_w), tgt);
`ifdef BOARD_GEN_NO_REPEAT_EN
    if (tgt < 8) check_val("no_repeat", board_m != old_m, 1);
`endif
    prev_m = exp_m;
    prev_w = exp_w;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_tiles = 4'd0;
    prev_m = 8'h00; prev_w = 8'h00;
    tick(); tick();
    check_val("rst_board", board_m, 0);
    check_val("rst_valid", valid_m, 0);
    check_val("rst_busy", busy_m, 0);
    check_val("rst_done", done_m, 0);
    check_val("rst_wd_board", board_w, 0);
    reset = 1'b0;
    check_val("rst_lfsr_seed", dut.u_lfsr.q, 16'hACE1);

    run_board(4'd3, 0, 4'd0);
    tick(); tick(); tick();
    check_val("valid_held", valid_m, 1);
    check_val("board_held", board_m, prev_m);

    run_board(4'd0, 0, 4'd0);
    run_board(4'd12, 0, 4'd0);
    check_val("clamp12_full", board_m, 8'hFF);
    run_board(4'd5, 3, 4'd2);

    // Abandon a fill with reset, asserting start in the same cycle.
    num_tiles = 4'd6; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1; start = 1'b1;
    tick();
    check_val("midrst_busy", busy_m, 0);
    check_val("midrst_valid", valid_m, 0);
    check_val("midrst_board", board_m, 0);
    check_val("midrst_wd_busy", busy_w, 0);
    reset = 1'b0; start = 1'b0;
    prev_m = 8'h00; prev_w = 8'h00;
    tick();
    check_val("rst_start_lost", busy_m, 0);
    run_board(4'd7, 0, 4'd0);

    for (int r = 0; r < 20; r++) begin
      int gap;
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) tick();
      run_board(4'($urandom_range(0, 15)), 0, 4'd0);
    end

    for (int r = 0; r < 50; r++) run_board(4'd4, 0, 4'd0);

    for (int r = 0; r < 4; r++) begin
      run_board(4'd8, 0, 4'd0);
      check_val("full_board_repeat", board_m, 8'hFF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_gen.md
Name: board_gen

Overview:
- Generates the hidden solution board for the memory-matrix game: an 8-tile bitmap with exactly N tiles lit.
- Sits directly upstream of the guess-check and display datapath.
- Triggered by the game FSM's start pulse.
- Uses a free-running LFSR so that the player's start timing seeds the pattern.
- Holds the finished board stable until the next start request.

Parameters:
- WIDTH, 8, number of tiles; must be a power of two, 2..16.
- SEED, 16'hACE1, LFSR value loaded on reset; must be nonzero.
- MAX_CYCLES, 255, fill watchdog limit in clock cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request for a new board.
- num_tiles  in  4  requested lit-tile count (difficulty).
- busy  out  1  high while a board is being filled.
- board_done  out  1  one-cycle pulse when a new board is ready.
- board_valid  out  1  high while board holds a completed pattern.
- board  out  WIDTH  solution bitmap; bit i = tile i lit.

Behaviour:
- Reset (sampled on rising clk, priority over everything):
  - lfsr=SEED, state=IDLE.
  - board=0, board_valid=0, board_done=0, busy=0.
  - accum=0, count=0, timer=0.
- LFSR:
  - 16-bit Galois, right shift, taps 16'hB400.
  - Advances every cycle in every state except reset; never reaches zero.
- Target clamp, latched on an accepted start:
  - num_tiles==0 -> 1.
  - num_tiles>WIDTH -> WIDTH.
  - otherwise num_tiles.
- States: IDLE, FILL, DONE.
- IDLE:
  - start=1 -> latch target; accum=0, count=0, timer=0; board_valid<=0; go FILL.
- FILL (busy=1):
  - Each cycle, idx = lfsr[log2(WIDTH)-1:0].
  - If accum[idx]==0: set it and count++.
  - Else: the sample is discarded.
  - timer increments every FILL cycle.
  - When the updated count==target, next cycle:
    - board<=accum, board_valid<=1, board_done<=1 for exactly one cycle.
    - busy<=0; go DONE.
- Watchdog:
  - If timer reaches MAX_CYCLES before completion, the next cycle sets the lowest clear bits of accum until popcount==target.
  - Then completes as above (same cycle semantics).
- DONE:
  - board and board_valid held.
  - start=1 -> same action as IDLE start (board_valid drops next cycle; board keeps the old value until the new completion).
- Start while busy: ignored. No queuing, no effect on the target.
- Latency: minimum target+1 cycles from start to board_done; maximum MAX_CYCLES+2.
- Reset mid-FILL: abandons the fill; all outputs return to reset values next cycle.
- Simultaneous reset and start: reset wins; start is lost.
- Invariant: popcount(board)==latched target whenever board_valid=1.

Optional Feature:
- Macro: BOARD_GEN_NO_REPEAT_EN.
- With the macro:
  - At completion, if the new accum equals the previously delivered board and target<WIDTH, the result is discarded.
  - accum/count are cleared and FILL restarts with timer reset.
  - board_done fires only for a differing board.
  - The previous board register clears on reset; the first board is always accepted.
  - The watchdog-forced result is exempt.
- Without the macro: consecutive identical boards are permitted; no previous-board register exists.

Decomposition:
- Shared package board_pkg holds:
  - BOARD_W=8.
  - The state enum (IDLE, FILL, DONE).
  - LFSR_TAPS=16'hB400.
  - DEFAULT_SEED=16'hACE1.
  - The clamp rule as a constant function.
- Game FSM and datapath import BOARD_W from the same package.
- One natural sub-module: lfsr16 (clk, reset, seed, q), instantiated once.
- Popcount and clamp logic stay inline.

Test Plan:
- Reset values: reset high 2 cycles -> board=0, board_valid=0, busy=0, board_done=0; lfsr=16'hACE1 on the first cycle after release.
- Normal fill: num_tiles=3, start 1 cycle -> busy 1 next cycle; board_done exactly once within 256 cycles; popcount(board)=3; board_valid held until the next start; board matches a bit-accurate reference model for the same start cycle offset.
- Clamping:
  - num_tiles=0 -> popcount(board)=1.
  - num_tiles=12 -> board=8'hFF after exactly 8 accepted sets; no watchdog.
- Start while busy: num_tiles=5, start pulsed again mid-FILL with num_tiles=2 -> single board_done; popcount=5.
- Reset mid-FILL: reset asserted 3 cycles after start -> busy=0 and board_valid=0 next cycle; a subsequent start produces a valid board.
- No-repeat (macro on): 50 back-to-back starts with num_tiles=4 -> no two consecutive boards equal. With num_tiles=8, identical 8'hFF boards are accepted every time.
